// File: rtl/sdram_cpu_bridge.sv
// Bridges the 16-bit CPU bus to the 32-bit SDRAM controller; sub-word stores become read-modify-write.
// Ack arrives 2 cycles after the completion edge while cpu_busy stalls the CPU; `SDRAM_BRIDGE_LINE_BUF_EN adds a one-word write-through buffer.
module sdram_cpu_bridge #(
  parameter int AW = 24
) (
  input  logic          CLOCK_50,
  input  logic          rst,
  input  logic [AW-1:0] cpu_addr,
  input  logic          cpu_rd,
  input  logic          cpu_wr,
  input  logic [1:0]    cpu_be,
  input  logic [15:0]   cpu_wdata,
  output logic [15:0]   cpu_rdata,
  output logic          cpu_ack,
  output logic          cpu_busy,
  output logic [AW-1:0] mem_address,
  output logic          mem_req_read,
  output logic          mem_req_write,
  output logic [31:0]   mem_wdata,
  input  logic [31:0]   mem_rdata,
  input  logic          mem_data_valid,
  input  logic          mem_write_complete
);

  typedef enum logic [2:0] {
    IDLE, RD_REQ, RD_WAIT, MERGE, WR_REQ, WR_WAIT, RESP
  } state_t;

  state_t        state, state_nxt;
  logic          dv_q, wc_q;
  logic          rd_rise, wc_rise;
  logic          accept, zero_wr, hit;
  logic [31:0]   hit_word;
  logic [AW-1:0] addr_q;
  logic [1:0]    be_q;
  logic [15:0]   wdata_q;
  logic          wr_q;
  logic [31:0]   word, merged;

  logic          ack_d, busy_d, req_read_d, req_write_d;
  logic [15:0]   rdata_d;
  logic [AW-1:0] address_d;
  logic [31:0]   wdata_d;

  // Only low-to-high transitions complete a transaction; stale levels are ignored.
  assign rd_rise = mem_data_valid & ~dv_q;
  assign wc_rise = mem_write_complete & ~wc_q;

  assign accept  = (state == IDLE) && !cpu_busy && (cpu_rd || cpu_wr);
  assign zero_wr = accept && cpu_wr && (cpu_be == 2'b00);

`ifdef SDRAM_BRIDGE_LINE_BUF_EN
  logic          buf_vld;
  logic [AW-2:0] buf_tag;
  logic [31:0]   buf_word;

  assign hit      = buf_vld && (buf_tag == cpu_addr[AW-1:1]);
  assign hit_word = buf_word;

  always_ff @(posedge CLOCK_50 or posedge rst) begin
    if (rst) begin
      buf_vld  <= 1'b0;
      buf_tag  <= '0;
      buf_word <= '0;
    end else if (state == RD_WAIT && rd_rise) begin
      buf_vld  <= 1'b1;
      buf_tag  <= addr_q[AW-1:1];
      buf_word <= mem_rdata;
    end else if (state == MERGE) begin
      buf_vld  <= 1'b1;
      buf_tag  <= addr_q[AW-1:1];
      buf_word <= merged;
    end
  end
`else
  assign hit      = 1'b0;
  assign hit_word = '0;
`endif

  always_comb begin
    merged = word;
    if (addr_q[0]) begin
      if (be_q[0]) merged[23:16] = wdata_q[7:0];
      if (be_q[1]) merged[31:24] = wdata_q[15:8];
    end else begin
      if (be_q[0]) merged[7:0]   = wdata_q[7:0];
      if (be_q[1]) merged[15:8]  = wdata_q[15:8];
    end
  end

  always_ff @(posedge CLOCK_50 or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (accept && !zero_wr) begin
          if (hit) state_nxt = cpu_wr ? MERGE : RESP;
          else     state_nxt = RD_REQ;
        end
      end
      RD_REQ:  state_nxt = RD_WAIT;
      RD_WAIT: if (rd_rise) state_nxt = wr_q ? MERGE : RESP;
      MERGE:   state_nxt = WR_REQ;
      WR_REQ:  state_nxt = WR_WAIT;
      WR_WAIT: if (wc_rise) state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Request strobes key off the next state so they are high during RD_REQ/WR_REQ itself.
  always_comb begin
    ack_d       = (state == RESP) || zero_wr;
    busy_d      = accept || (cpu_busy && !cpu_ack);
    rdata_d     = cpu_rdata;
    if (state == RESP) rdata_d = addr_q[0] ? word[31:16] : word[15:0];
    req_read_d  = (state_nxt == RD_REQ);
    req_write_d = (state_nxt == WR_REQ);
    address_d   = mem_address;
    wdata_d     = mem_wdata;
    if (state_nxt == RD_REQ) address_d = {cpu_addr[AW-1:1], 1'b0};
    if (state_nxt == WR_REQ) begin
      address_d = {addr_q[AW-1:1], 1'b0};
      wdata_d   = merged;
    end
  end

  always_ff @(posedge CLOCK_50 or posedge rst) begin
    if (rst) begin
      cpu_ack       <= 1'b0;
      cpu_busy      <= 1'b0;
      cpu_rdata     <= '0;
      mem_req_read  <= 1'b0;
      mem_req_write <= 1'b0;
      mem_address   <= '0;
      mem_wdata     <= '0;
      dv_q          <= 1'b0;
      wc_q          <= 1'b0;
    end else begin
      cpu_ack       <= ack_d;
      cpu_busy      <= busy_d;
      cpu_rdata     <= rdata_d;
      mem_req_read  <= req_read_d;
      mem_req_write <= req_write_d;
      mem_address   <= address_d;
      mem_wdata     <= wdata_d;
      dv_q          <= mem_data_valid;
      wc_q          <= mem_write_complete;
    end
  end

  always_ff @(posedge CLOCK_50 or posedge rst) begin
    if (rst) begin
      addr_q  <= '0;
      be_q    <= '0;
      wdata_q <= '0;
      wr_q    <= 1'b0;
      word    <= '0;
    end else begin
      if (accept) begin
        addr_q  <= cpu_addr;
        be_q    <= cpu_be;
        wdata_q <= cpu_wdata;
        wr_q    <= cpu_wr;
      end
      if (accept && hit)                    word <= hit_word;
      else if (state == RD_WAIT && rd_rise) word <= mem_rdata;
      else if (state == MERGE)              word <= merged;
    end
  end

endmodule

// File: tb/tb_sdram_cpu_bridge.sv
// Randomized bench for sdram_cpu_bridge against a halfword-level memory model and a behavioural SDRAM controller.
module tb_sdram_cpu_bridge;
  localparam int AW = 24;
`ifdef SDRAM_BRIDGE_LINE_BUF_EN
  localparam bit LINEBUF = 1'b1;
`else
  localparam bit LINEBUF = 1'b0;
`endif

  logic          CLOCK_50 = 1'b0;
  logic          rst;
  logic [AW-1:0] cpu_addr;
  logic          cpu_rd, cpu_wr;
  logic [1:0]    cpu_be;
  logic [15:0]   cpu_wdata, cpu_rdata;
  logic          cpu_ack, cpu_busy;
  logic [AW-1:0] mem_address;
  logic          mem_req_read, mem_req_write;
  logic [31:0]   mem_wdata, mem_rdata;
  logic          mem_data_valid, mem_write_complete;

  logic          auto_en, auto_dv, auto_wc, man_dv;
  logic [31:0]   auto_rdata, man_rdata;
  int            wr_delay;

  assign mem_data_valid     = auto_dv | man_dv;
  assign mem_rdata          = man_dv ? man_rdata : auto_rdata;
  assign mem_write_complete = auto_wc;

  always #5 CLOCK_50 = ~CLOCK_50;

  sdram_cpu_bridge #(.AW(AW)) dut (
    .CLOCK_50(CLOCK_50), .rst(rst),
    .cpu_addr(cpu_addr), .cpu_rd(cpu_rd), .cpu_wr(cpu_wr), .cpu_be(cpu_be),
    .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .cpu_ack(cpu_ack), .cpu_busy(cpu_busy),
    .mem_address(mem_address), .mem_req_read(mem_req_read), .mem_req_write(mem_req_write),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_data_valid(mem_data_valid),
    .mem_write_complete(mem_write_complete)
  );

  int n_chk = 0;
  int n_bad = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // CPU-visible memory as 16-bit halves; SDRAM contents as 32-bit words.
  logic [15:0] ref_mem [int];
  logic [31:0] sdram [int];
  bit          buf_valid;
  logic [AW-2:0] buf_tag;

  function automatic logic [31:0] init_word(int w);
    return (32'(w) + 32'd1) * 32'h9E3779B1;
  endfunction

  function automatic logic [31:0] sdram_get(int w);
    if (sdram.exists(w)) return sdram[w];
    return init_word(w);
  endfunction

  function automatic logic [15:0] ref_get(int ha);
    logic [31:0] iw;
    if (ref_mem.exists(ha)) return ref_mem[ha];
    iw = init_word(ha / 2);
    return (ha % 2 == 1) ? iw[31:16] : iw[15:0];
  endfunction

  task automatic preset(input int w, input logic [31:0] val);
    sdram[w]         = val;
    ref_mem[2*w]     = val[15:0];
    ref_mem[2*w + 1] = val[31:16];
  endtask

  int            cyc = 0;
  int            dv_cyc = 0, wc_cyc = 0;
  logic          dv_prev = 1'b0, wc_prev = 1'b0;
  int            rd_reqs = 0, wr_reqs = 0, ack_cnt = 0;
  logic [AW-1:0] last_req_addr = '0;
  logic [31:0]   last_wr_word = '0;

  always @(posedge CLOCK_50) begin
    if (mem_data_valid && !dv_prev)     dv_cyc <= cyc;
    if (mem_write_complete && !wc_prev) wc_cyc <= cyc;
    dv_prev <= mem_data_valid;
    wc_prev <= mem_write_complete;
    cyc     <= cyc + 1;
  end

  always @(negedge CLOCK_50) begin
    if (mem_req_read)  rd_reqs <= rd_reqs + 1;
    if (mem_req_write) wr_reqs <= wr_reqs + 1;
    if (cpu_ack)       ack_cnt <= ack_cnt + 1;
    if (mem_req_read || mem_req_write) last_req_addr <= mem_address;
    if (mem_req_write) last_wr_word <= mem_wdata;
  end

  // Behavioural controller: random latency, valid held 1-2 cycles, write-complete 1-3 cycles.
  initial begin
    int w;
    logic [31:0] wv;
    auto_dv = 1'b0; auto_wc = 1'b0; auto_rdata = '0;
    forever begin
      if (auto_en && mem_req_read) begin
        w = int'(mem_address[AW-1:1]);
        repeat ($urandom_range(1, 4)) @(negedge CLOCK_50);
        auto_rdata = sdram_get(w);
        auto_dv    = 1'b1;
        repeat ($urandom_range(1, 2)) @(negedge CLOCK_50);
        auto_dv    = 1'b0;
        auto_rdata = $urandom;
      end else if (auto_en && mem_req_write) begin
        w  = int'(mem_address[AW-1:1]);
        wv = mem_wdata;
        repeat (wr_delay != 0 ? wr_delay : $urandom_range(1, 4)) @(negedge CLOCK_50);
        sdram[w] = wv;
        auto_wc  = 1'b1;
        repeat ($urandom_range(1, 3)) @(negedge CLOCK_50);
        auto_wc  = 1'b0;
      end else begin
        @(negedge CLOCK_50);
      end
    end
  end

  task automatic do_op(input logic rd, input logic wr, input logic [AW-1:0] a,
                       input logic [1:0] be, input logic [15:0] wd, output logic [15:0] rdat);
    int   t, ack_c, rr0, wr0, ha, hb;
    logic got, zero, hit;
    logic [15:0] h;
    rdat = '0; got = 1'b0; ack_c = 0;
    for (int i = 0; i < 100 && cpu_busy; i++) @(negedge CLOCK_50);
    if (cpu_busy) begin
      check_val("idle_timeout", 32'(cpu_busy), 32'd0);
      return;
    end
    ha   = int'(a);
    hb   = ha - (ha % 2);
    zero = wr && (be == 2'b00);
    hit  = LINEBUF && buf_valid && (buf_tag == a[AW-1:1]);
    rr0  = rd_reqs;
    wr0  = wr_reqs;
    cpu_addr = a; cpu_be = be; cpu_wdata = wd; cpu_rd = rd; cpu_wr = wr;
    t = cyc;
    @(negedge CLOCK_50);
    cpu_rd = 1'b0; cpu_wr = 1'b0;
    for (int i = 0; i < 200 && !got; i++) begin
      if (cpu_ack) begin
        got = 1'b1; ack_c = cyc; rdat = cpu_rdata;
      end else begin
        @(negedge CLOCK_50);
      end
    end
    if (!got) begin
      check_val("ack_timeout", 32'd0, 32'd1);
      return;
    end
    check_val("busy_at_ack", 32'(cpu_busy), 32'd1);
    @(negedge CLOCK_50);
    check_val("busy_after_ack", 32'(cpu_busy), 32'd0);
    if (wr) begin
      if (zero) begin
        check_val("wr0_lat", ack_c - t, 32'd1);
        check_val("wr0_rdreq", rd_reqs - rr0, 32'd0);
        check_val("wr0_wrreq", wr_reqs - wr0, 32'd0);
      end else begin
        h = ref_get(ha);
        if (be[0]) h[7:0]  = wd[7:0];
        if (be[1]) h[15:8] = wd[15:8];
        ref_mem[ha] = h;
        check_val("wr_lat", ack_c - wc_cyc, 32'd2);
        check_val("wr_rdreq", rd_reqs - rr0, hit ? 32'd0 : 32'd1);
        check_val("wr_wrreq", wr_reqs - wr0, 32'd1);
        check_val("wr_addr", 32'(last_req_addr), 32'({a[AW-1:1], 1'b0}));
        check_val("wr_word", last_wr_word, {ref_get(hb + 1), ref_get(hb)});
      end
    end else begin
      check_val("rd_data", 32'(rdat), 32'(ref_get(ha)));
      if (hit) begin
        check_val("rd_hit_lat", ack_c - t, 32'd2);
      end else begin
        check_val("rd_lat", ack_c - dv_cyc, 32'd2);
        check_val("rd_addr", 32'(last_req_addr), 32'({a[AW-1:1], 1'b0}));
      end
      check_val("rd_rdreq", rd_reqs - rr0, hit ? 32'd0 : 32'd1);
      check_val("rd_wrreq", wr_reqs - wr0, 32'd0);
    end
    if (!zero) begin
      buf_valid = 1'b1;
      buf_tag   = a[AW-1:1];
    end
  endtask

  initial begin
    logic [15:0] rd_v;
    logic        seen;
    int          a0;
    rst = 1'b1;
    cpu_addr = '0; cpu_rd = 1'b0; cpu_wr = 1'b0; cpu_be = '0; cpu_wdata = '0;
    auto_en = 1'b1; man_dv = 1'b0; man_rdata = '0; wr_delay = 0;
    buf_valid = 1'b0; buf_tag = '0;
    preset('h80, 32'hBEEF1234);
    preset('h100, 32'h11223344);

    repeat (3) @(negedge CLOCK_50);
    check_val("rst_ack", 32'(cpu_ack), 32'd0);
    check_val("rst_busy", 32'(cpu_busy), 32'd0);
    check_val("rst_rdata", 32'(cpu_rdata), 32'd0);
    check_val("rst_req_rd", 32'(mem_req_read), 32'd0);
    check_val("rst_req_wr", 32'(mem_req_write), 32'd0);
    check_val("rst_addr", 32'(mem_address), 32'd0);
    check_val("rst_wdata", mem_wdata, 32'd0);
    rst = 1'b0;
    repeat (2) @(negedge CLOCK_50);

    do_op(1'b1, 1'b0, 24'h000101, 2'b11, 16'h0000, rd_v);
    check_val("miss_val", 32'(rd_v), 32'h0000BEEF);
    check_val("miss_addr", 32'(last_req_addr), 32'h00000100);

    do_op(1'b0, 1'b1, 24'h000200, 2'b01, 16'hAAFF, rd_v);
    check_val("rmw_word", last_wr_word, 32'h112233FF);

    do_op(1'b1, 1'b0, 24'h000201, 2'b00, 16'h0000, rd_v);
    check_val("hit_val", 32'(rd_v), 32'h00001122);

    do_op(1'b1, 1'b1, 24'h000000, 2'b11, 16'h5A5A, rd_v);
    check_val("both_lo", 32'(last_wr_word[15:0]), 32'h00005A5A);
    do_op(1'b1, 1'b0, 24'h000000, 2'b00, 16'h0000, rd_v);
    check_val("both_rd", 32'(rd_v), 32'h00005A5A);

    do_op(1'b0, 1'b1, 24'h000200, 2'b00, 16'h1234, rd_v);

    // Valid already high before the request must not complete the read.
    auto_en   = 1'b0;
    man_rdata = 32'hDEADDEAD;
    man_dv    = 1'b1;
    repeat (2) @(negedge CLOCK_50);
    a0 = ack_cnt;
    fork
      do_op(1'b1, 1'b0, 24'h000300, 2'b11, 16'h0000, rd_v);
      begin
        repeat (12) @(negedge CLOCK_50);
        check_val("stale_hold", 32'(cpu_busy & ~cpu_ack), 32'd1);
        man_dv = 1'b0;
        @(negedge CLOCK_50);
        man_rdata = sdram_get('h180);
        man_dv    = 1'b1;
        repeat (2) @(negedge CLOCK_50);
        man_dv    = 1'b0;
      end
    join
    repeat (2) @(negedge CLOCK_50);
    check_val("stale_one_ack", ack_cnt - a0, 32'd1);
    auto_en = 1'b1;

    // Reset during WR_WAIT; the controller still finishes the write afterwards.
    wr_delay = 20;
    cpu_addr = 24'h000206; cpu_be = 2'b11; cpu_wdata = 16'h1357; cpu_wr = 1'b1;
    @(negedge CLOCK_50);
    cpu_wr = 1'b0;
    ref_mem['h206] = 16'h1357;
    seen = 1'b0;
    for (int i = 0; i < 60 && !seen; i++) begin
      if (mem_req_write) seen = 1'b1;
      else @(negedge CLOCK_50);
    end
    check_val("rstw_req_seen", 32'(seen), 32'd1);
    @(negedge CLOCK_50);
    #2 rst = 1'b1;
    #1;
    check_val("rstw_ack", 32'(cpu_ack), 32'd0);
    check_val("rstw_busy", 32'(cpu_busy), 32'd0);
    check_val("rstw_rdata", 32'(cpu_rdata), 32'd0);
    check_val("rstw_req_rd", 32'(mem_req_read), 32'd0);
    check_val("rstw_req_wr", 32'(mem_req_write), 32'd0);
    check_val("rstw_addr", 32'(mem_address), 32'd0);
    check_val("rstw_wdata", mem_wdata, 32'd0);
    @(negedge CLOCK_50);
    rst = 1'b0;
    buf_valid = 1'b0;
    a0 = ack_cnt;
    repeat (30) @(negedge CLOCK_50);
    check_val("rstw_no_ack", ack_cnt - a0, 32'd0);
    check_val("rstw_idle", 32'(cpu_busy), 32'd0);
    wr_delay = 0;
    do_op(1'b1, 1'b0, 24'h000206, 2'b00, 16'h0000, rd_v);
    check_val("rstw_rd_val", 32'(rd_v), 32'h00001357);

    for (int n = 0; n < 60; n++) begin
      int r;
      r = $urandom_range(0, 9);
      do_op(r < 5 || r == 9, r >= 5, 24'($urandom_range(0, 15)), 2'($urandom_range(0, 3)),
            16'($urandom), rd_v);
    end

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

endmodule
